uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Sits between the UART byte receiver (8-bit `out` plus one-cycle `valid`) and the CPU.
- Buffers received bytes in a small FIFO.
- Schedules the FIFO between two consumers: the boot loader first, then CPU `in` byte reads.
- Boot loader takes a length-prefixed word stream and writes it into instruction memory, then hands the FIFO to the CPU.

Parameters:
DEPTH_LOG, 4, log2 of FIFO depth in bytes (depth 16).
ADDR_WIDTH, 14, instruction memory word-address width.

Ports:
CLK  in  1  system clock; all logic on posedge.
RST  in  1  synchronous active-high reset.
rx_data  in  8  byte from receiver.
rx_valid  in  1  one-cycle pulse; rx_data valid this cycle.
boot_en  in  1  sampled while RST=1; selects boot or direct run.
inst_we  out  1  one-cycle instruction-memory write strobe.
inst_addr  out  ADDR_WIDTH  word address for inst_we.
inst_data  out  32  word for inst_we.
boot_done  out  1  level; 1 in RUN.
cpu_req  in  1  level; CPU wants one byte.
cpu_ack  out  1  one-cycle pulse; cpu_data valid this cycle.
cpu_data  out  8  byte delivered to CPU.
rx_overrun  out  1  sticky; a byte was dropped on a full FIFO.
fifo_count  out  DEPTH_LOG+1  current FIFO occupancy.

Behaviour:
- **Reset.** All outputs 0, FIFO emptied, counters 0. FSM <= boot_en ? BOOT_LEN : RUN. rx_overrun clears only on RST.
- **FIFO push.** On rx_valid:
  - not full: push.
  - full with no pop this cycle: drop the byte, set rx_overrun.
  - full with a pop this cycle: push accepted, count unchanged.
- **FIFO pop.** Pop decisions use the current-cycle count. Empty plus a simultaneous push gives no pop; the byte is poppable the next cycle. Pointers wrap modulo depth.
- **BOOT_LEN.**
  - Pops one byte per cycle when non-empty.
  - Shifts 4 bytes big-endian into a 32-bit count N.
  - After the 4th byte: N==0 goes to RUN (or CKSUM if the macro is on), else BOOT_DATA.
- **BOOT_DATA.**
  - Pops one byte per cycle and shifts it big-endian into the word register.
  - Cycle after each 4th byte: inst_we=1, inst_data=word, inst_addr=word index (starts 0, wraps modulo 2^ADDR_WIDTH).
  - After the N-th word write, goes to the next state (CKSUM or RUN).
  - Byte-pop throughput is unaffected by the write cycle.
- **RUN.**
  - boot_done=1.
  - Each cycle with cpu_req=1, FIFO non-empty and cpu_ack=0: pop the head. Next cycle cpu_ack=1 and cpu_data=that byte.
  - Maximum rate is one byte per 2 cycles; the CPU must drop cpu_req in the ack cycle to take only one byte.
  - Empty FIFO: no ack, and the request is held.
  - cpu_req is ignored in all boot states.
- **cpu_data.** Holds its last value between acks.
- **Reset mid-operation.** Any state returns to its reset values: a partial word or count is discarded and the FIFO is flushed.

Optional Feature:
Macro: UART_RX_BOOT_CKSUM_EN
- **Defined.**
  - Adds output boot_err (1 bit) and state CKSUM.
  - After the last word (or N==0), one more byte is popped and compared to the 8-bit modulo-256 sum of all data bytes; length bytes are excluded.
  - Match: go to RUN.
  - Mismatch: go to ERR with boot_err=1 and boot_done=0. The FIFO keeps accepting bytes but is never popped, and ERR is left only via RST.
- **Undefined.** No boot_err port and no CKSUM/ERR states; the boot loader goes straight to RUN after the last word.

Decomposition:
- Package `uart_rx_ctrl_pkg`:
  - state enum typedef (BOOT_LEN, BOOT_DATA, CKSUM, RUN, ERR);
  - BYTES_PER_WORD=4;
  - 32-bit word typedef.
- One sub-module: `rx_byte_fifo` (push/pop/full/empty/count, DEPTH_LOG parameter). The controller instantiates it once.

Test Plan:
1. boot_en=1; send 00 00 00 02 11 22 33 44 AA BB CC DD -> inst_we twice: addr0=0x11223344, addr1=0xAABBCCDD; then boot_done=1 and no cpu_ack during boot.
2. boot_en=0; push 5A, 3C; hold cpu_req=1 -> cpu_ack pulses on alternate cycles with data 5A then 3C; no further ack once empty; a new byte pushed later is acked.
3. cpu_req=0; push 17 bytes -> fifo_count=16, rx_overrun=1; reading back gives the first 16 in order and the 17th is lost; a push concurrent with a pop at full is kept.
4. boot_en=1; length 00 00 00 00 -> boot_done=1 within 2 cycles of the 4th byte pop, no inst_we.
5. boot_en=1; length 3, RST pulsed after the 2nd word -> all outputs 0, FIFO count 0; a fresh length-1 stream boots correctly to addr0.
6. Macro on: boot length 1, word 01 02 03 04, checksum 0A -> RUN. Checksum 0B instead -> boot_err=1, boot_done=0, cpu_req never acked.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types for the UART receive controller: FSM states, word type, byte shifter.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT_LEN,
    ST_BOOT_DATA,
    ST_CKSUM,
    ST_RUN,
    ST_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [31:0] word_t;

  // Big-endian accumulation: earlier bytes end up in the high bits.
  function automatic word_t shift_in_byte(input word_t w, input logic [7:0] b);
    return {w[23:0], b};
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Byte FIFO of depth 2**DEPTH_LOG with registered occupancy count.
// Caller guarantees push only when accepted and pop only when non-empty.
module rx_byte_fifo #(
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [7:0]           push_data,
  input  logic                 pop,
  output logic [7:0]           head,
  output logic [DEPTH_LOG:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;

  assign full  = (count == (DEPTH_LOG+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Buffers UART bytes and serves them to the boot loader, then to CPU reads.
// Optional boot checksum/error state enabled by UART_RX_BOOT_CKSUM_EN.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG  = 4,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  boot_en,
  output logic                  inst_we,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           inst_data,
  output logic                  boot_done,
  input  logic                  cpu_req,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_data,
`ifdef UART_RX_BOOT_CKSUM_EN
  output logic                  boot_err,
`endif
  output logic                  rx_overrun,
  output logic [DEPTH_LOG:0]    fifo_count
);

`ifdef UART_RX_BOOT_CKSUM_EN
  localparam state_t ST_AFTER_BOOT = ST_CKSUM;
`else
  localparam state_t ST_AFTER_BOOT = ST_RUN;
`endif

  state_t                state, state_next;
  logic [7:0]            head;
  logic                  full, empty;
  logic                  fifo_push, fifo_pop;
  logic                  boot_pop, run_pop, ck_pop;
  logic [1:0]            byte_cnt;
  logic                  last_byte;
  word_t                 shreg, shifted, rem;
  logic [ADDR_WIDTH-1:0] addr_cnt;
`ifdef UART_RX_BOOT_CKSUM_EN
  logic [7:0]            sum;
`endif

  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign shifted   = shift_in_byte(shreg, head);
  assign fifo_pop  = boot_pop | run_pop | ck_pop;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign fifo_push = rx_valid && (!full || fifo_pop);

  rx_byte_fifo #(.DEPTH_LOG(DEPTH_LOG)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (fifo_push),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_next = state;
    boot_pop   = 1'b0;
    run_pop    = 1'b0;
    ck_pop     = 1'b0;
    case (state)
      ST_BOOT_LEN: begin
        if (!empty) begin
          boot_pop = 1'b1;
          if (last_byte) state_next = (shifted == '0) ? ST_AFTER_BOOT : ST_BOOT_DATA;
        end
      end
      ST_BOOT_DATA: begin
        // rem reaches zero in the cycle of the last word write; leave afterwards.
        if (rem == '0)  state_next = ST_AFTER_BOOT;
        else if (!empty) boot_pop = 1'b1;
      end
`ifdef UART_RX_BOOT_CKSUM_EN
      ST_CKSUM: begin
        if (!empty) begin
          ck_pop     = 1'b1;
          state_next = (head == sum) ? ST_RUN : ST_ERR;
        end
      end
`endif
      ST_RUN: run_pop = cpu_req && !empty && !cpu_ack;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= boot_en ? ST_BOOT_LEN : ST_RUN;
      boot_done  <= 1'b0;
      inst_we    <= 1'b0;
      inst_addr  <= '0;
      inst_data  <= '0;
      cpu_ack    <= 1'b0;
      cpu_data   <= '0;
      rx_overrun <= 1'b0;
      byte_cnt   <= '0;
      shreg      <= '0;
      rem        <= '0;
      addr_cnt   <= '0;
`ifdef UART_RX_BOOT_CKSUM_EN
      sum        <= '0;
      boot_err   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      boot_done <= (state_next == ST_RUN);
      inst_we   <= 1'b0;
      cpu_ack   <= run_pop;
      if (run_pop) cpu_data <= head;
      if (rx_valid && full && !fifo_pop) rx_overrun <= 1'b1;
      if (boot_pop) begin
        shreg    <= shifted;
        byte_cnt <= byte_cnt + 1'b1;
        if (state == ST_BOOT_LEN && last_byte) rem <= shifted;
        if (state == ST_BOOT_DATA) begin
`ifdef UART_RX_BOOT_CKSUM_EN
          sum <= sum + head;
`endif
          if (last_byte) begin
            inst_we   <= 1'b1;
            inst_data <= shifted;
            inst_addr <= addr_cnt;
            addr_cnt  <= addr_cnt + 1'b1;
            rem       <= rem - 1'b1;
          end
        end
      end
`ifdef UART_RX_BOOT_CKSUM_EN
      boot_err <= (state_next == ST_ERR);
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: per-cycle vector tables plus hand-written corner sequences.
module tb_uart_rx_ctrl;

  logic        CLK, RST;
  logic [7:0]  rx_data;
  logic        rx_valid, boot_en, cpu_req;
  logic        inst_we, boot_done, cpu_ack, rx_overrun;
  logic [13:0] inst_addr;
  logic [31:0] inst_data;
  logic [7:0]  cpu_data;
  logic [4:0]  fifo_count;
`ifdef UART_RX_BOOT_CKSUM_EN
  logic        boot_err;
`endif

  uart_rx_ctrl #(.DEPTH_LOG(4), .ADDR_WIDTH(14)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .boot_en(boot_en),
    .inst_we(inst_we), .inst_addr(inst_addr), .inst_data(inst_data), .boot_done(boot_done),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
`ifdef UART_RX_BOOT_CKSUM_EN
    .boot_err(boot_err),
`endif
    .rx_overrun(rx_overrun), .fifo_count(fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rv;
    logic [7:0]  rd;
    logic        req;
    logic        we;
    logic [13:0] addr;
    logic [31:0] dat;
    logic        done;
    logic        ack;
    logic [7:0]  cd;
    logic [4:0]  cnt;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  int          we_cnt = 0;
  logic [13:0] we_addr_last;
  logic [31:0] we_data_last;

  always @(negedge CLK) begin
    if (inst_we) begin
      we_cnt       <= we_cnt + 1;
      we_addr_last <= inst_addr;
      we_data_last <= inst_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [7:0] rd, input logic req,
                              input logic we, input logic [13:0] addr, input logic [31:0] dat,
                              input logic done, input logic ack, input logic [7:0] cd,
                              input logic [4:0] cnt);
    vec_t v;
    v.rv = rv; v.rd = rd; v.req = req; v.we = we; v.addr = addr; v.dat = dat;
    v.done = done; v.ack = ack; v.cd = cd; v.cnt = cnt;
    return v;
  endfunction

  task automatic apply_vec(input string tag, input int i, input vec_t v);
    rx_valid = v.rv;
    rx_data  = v.rd;
    cpu_req  = v.req;
    @(posedge CLK); #1;
    chk($sformatf("%s[%0d].inst_we", tag, i), 32'(inst_we), 32'(v.we));
    if (v.we) begin
      chk($sformatf("%s[%0d].inst_addr", tag, i), 32'(inst_addr), 32'(v.addr));
      chk($sformatf("%s[%0d].inst_data", tag, i), inst_data, v.dat);
    end
    chk($sformatf("%s[%0d].boot_done", tag, i), 32'(boot_done), 32'(v.done));
    chk($sformatf("%s[%0d].cpu_ack", tag, i), 32'(cpu_ack), 32'(v.ack));
    chk($sformatf("%s[%0d].cpu_data", tag, i), 32'(cpu_data), 32'(v.cd));
    chk($sformatf("%s[%0d].fifo_count", tag, i), 32'(fifo_count), 32'(v.cnt));
  endtask

  task automatic do_reset(input logic be, input string tag);
    RST = 1'b1; boot_en = be; rx_valid = 1'b0; rx_data = 8'h00; cpu_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk({tag, ".inst_we"}, 32'(inst_we), 0);
    chk({tag, ".inst_addr"}, 32'(inst_addr), 0);
    chk({tag, ".inst_data"}, inst_data, 0);
    chk({tag, ".boot_done"}, 32'(boot_done), 0);
    chk({tag, ".cpu_ack"}, 32'(cpu_ack), 0);
    chk({tag, ".cpu_data"}, 32'(cpu_data), 0);
    chk({tag, ".rx_overrun"}, 32'(rx_overrun), 0);
    chk({tag, ".fifo_count"}, 32'(fifo_count), 0);
    RST = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[$];
    vec_t t2[$];
    int   base, idx;
    logic [7:0] exp_b;
    logic [7:0] len1 [8];

    // Boot with N=2: bytes arrive one per cycle, each popped the cycle after it lands.
    t1.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'h02, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'h11, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'h22, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'h33, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'h44, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'hAA, 1, 1, 14'd0, 32'h11223344, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'hBB, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'hCC, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(1, 8'hDD, 1, 0, 0, 0, 0, 0, 0, 1));
    t1.push_back(mk(0, 8'h00, 1, 1, 14'd1, 32'hAABBCCDD, 0, 0, 0, 0));
    t1.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));
    t1.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));

    // Direct run: acks on alternate cycles, cpu_data holds between acks.
    t2.push_back(mk(1, 8'h5A, 1, 0, 0, 0, 1, 0, 8'h00, 1));
    t2.push_back(mk(1, 8'h3C, 1, 0, 0, 0, 1, 1, 8'h5A, 1));
    t2.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h5A, 1));
    t2.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h3C, 0));
    t2.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h3C, 0));
    t2.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h3C, 0));
    t2.push_back(mk(1, 8'h77, 1, 0, 0, 0, 1, 0, 8'h3C, 1));
    t2.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h77, 0));
    t2.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h77, 0));

    do_reset(1'b1, "t1_reset");
    foreach (t1[i]) apply_vec("t1", i, t1[i]);

    do_reset(1'b0, "t2_reset");
    foreach (t2[i]) apply_vec("t2", i, t2[i]);

    // Overrun: 17 pushes into a 16-deep FIFO, then a push concurrent with a pop at full.
    do_reset(1'b0, "t3_reset");
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(8'h10 + i));
      if (i == 15) begin
        chk("t3.count_at_16", 32'(fifo_count), 16);
        chk("t3.no_overrun_yet", 32'(rx_overrun), 0);
      end
    end
    chk("t3.count_full", 32'(fifo_count), 16);
    chk("t3.overrun", 32'(rx_overrun), 1);
    rx_valid = 1'b1; rx_data = 8'hEE; cpu_req = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    chk("t3.first_ack", 32'(cpu_ack), 1);
    chk("t3.first_data", 32'(cpu_data), 32'h10);
    chk("t3.count_push_pop_full", 32'(fifo_count), 16);
    idx = 1;
    for (int c = 0; c < 60 && idx < 17; c++) begin
      @(posedge CLK); #1;
      if (cpu_ack) begin
        exp_b = (idx < 16) ? 8'(8'h10 + idx) : 8'hEE;
        chk($sformatf("t3.read[%0d]", idx), 32'(cpu_data), 32'(exp_b));
        idx++;
      end
    end
    chk("t3.reads_total", 32'(idx), 17);
    chk("t3.count_drained", 32'(fifo_count), 0);
    chk("t3.overrun_sticky", 32'(rx_overrun), 1);
    cpu_req = 1'b0;

    // Zero-length boot goes straight to RUN with no writes.
    do_reset(1'b1, "t4_reset");
    base = we_cnt;
    repeat (4) push_byte(8'h00);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("t4.boot_done", 32'(boot_done), 1);
    chk("t4.no_writes", 32'(we_cnt - base), 0);

    // Reset in the middle of a length-3 boot, then a clean length-1 boot.
    do_reset(1'b1, "t5_reset_a");
    base = we_cnt;
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h00); push_byte(8'h03);
    for (int i = 0; i < 10; i++) push_byte(8'(8'h11 + i));
    repeat (2) @(posedge CLK);
    #1;
    chk("t5.two_writes", 32'(we_cnt - base), 2);
    chk("t5.word1", we_data_last, 32'h15161718);
    chk("t5.still_booting", 32'(boot_done), 0);
    do_reset(1'b1, "t5_midreset");
    base = we_cnt;
    len1 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (len1[i]) push_byte(len1[i]);
    repeat (3) @(posedge CLK);
    #1;
    chk("t5.one_write", 32'(we_cnt - base), 1);
    chk("t5.addr0", 32'(we_addr_last), 0);
    chk("t5.data0", we_data_last, 32'hDEADBEEF);
    chk("t5.boot_done", 32'(boot_done), 1);

`ifdef UART_RX_BOOT_CKSUM_EN
    do_reset(1'b1, "t6_reset_a");
    len1 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    foreach (len1[i]) push_byte(len1[i]);
    push_byte(8'h0A);
    repeat (4) @(posedge CLK);
    #1;
    chk("t6.good_done", 32'(boot_done), 1);
    chk("t6.good_err", 32'(boot_err), 0);
    chk("t6.good_word", we_data_last, 32'h01020304);
    do_reset(1'b1, "t6_reset_b");
    foreach (len1[i]) push_byte(len1[i]);
    push_byte(8'h0B);
    repeat (4) @(posedge CLK);
    #1;
    chk("t6.bad_err", 32'(boot_err), 1);
    chk("t6.bad_done", 32'(boot_done), 0);
    cpu_req = 1'b1;
    push_byte(8'h55);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      if (cpu_ack) idx++;
    end
    chk("t6.err_no_ack", 32'(idx), 0);
    chk("t6.err_fifo_holds", 32'(fifo_count), 1);
    cpu_req = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
